// File: rtl/main_control_fsm_pkg.sv
// Shared encodings for the multicycle main control FSM: states, opcodes,
// ALU operation selects and the bundled datapath control word.
package main_control_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_ILLEGAL = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/main_control_fsm_decode.sv
// Moore output decode: maps the current state to the full datapath control
// word. Anything not set for a state stays 0.
module control_output_decode
  import main_control_fsm_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_write  = 1'b1;
      end
      S_DECODE: begin
        ctrl.alu_src_b = 2'b11;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b00;
        ctrl.alu_op    = ALUOP_FUNC;
      end
      S_RWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = 2'b00;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 2'b01;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = 2'b10;
      end
      S_ILLEGAL: begin
        ctrl.illegal = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/main_control_fsm.sv
// Multicycle main control FSM: state register, opcode latch and next-state
// logic; output decode lives in control_output_decode.
module main_control_fsm
  import main_control_fsm_pkg::*;
#(
  parameter bit ADDI_EN = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] Opcode,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic       Illegal,
  output logic [3:0] State
);

  state_t     cur_state;
  logic [5:0] opcode_q;
  logic       hold;
  ctrl_t      ctrl;

  // hold keeps FETCH for one extra edge after reset so the first fetch
  // strobes are seen for a full cycle before moving on.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_state <= S_FETCH;
      opcode_q  <= '0;
      hold      <= 1'b1;
    end else begin
      hold <= 1'b0;
      case (cur_state)
        S_FETCH:  if (!hold) cur_state <= S_DECODE;
        S_DECODE: begin
          opcode_q <= Opcode;
          case (Opcode)
            OP_LW, OP_SW: cur_state <= S_MEMADR;
            OP_R:         cur_state <= S_EXEC;
            OP_BEQ:       cur_state <= S_BRANCH;
            OP_J:         cur_state <= S_JUMP;
            OP_ADDI:      cur_state <= ADDI_EN ? S_ADDIEX : S_ILLEGAL;
            default:      cur_state <= S_ILLEGAL;
          endcase
        end
        S_MEMADR: cur_state <= (opcode_q == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  cur_state <= S_MEMWB;
        S_EXEC:   cur_state <= S_RWB;
        S_ADDIEX: cur_state <= S_ADDIWB;
        default:  cur_state <= S_FETCH;
      endcase
    end
  end

  control_output_decode u_decode (
    .state (cur_state),
    .ctrl  (ctrl)
  );

  // Fetch-side strobes are held off while reset is asserted.
  assign PCWrite     = ctrl.pc_write & ~reset;
  assign IRWrite     = ctrl.ir_write & ~reset;
  assign MemRead     = ctrl.mem_read & ~reset;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.i_or_d;
  assign MemWrite    = ctrl.mem_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegWrite    = ctrl.reg_write;
  assign RegDst      = ctrl.reg_dst;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUOp       = ctrl.alu_op;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign PCSource    = ctrl.pc_source;
  assign Illegal     = ctrl.illegal;
  assign State       = cur_state;

endmodule

// File: tb/tb_main_control_fsm.sv
// Bench for main_control_fsm: path-based instruction model checked every
// cycle, plus directed instruction sequences with literal expectations.
module tb_main_control_fsm;
  import main_control_fsm_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] Opcode;

  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegWrite, RegDst, ALUSrcA, Illegal;
  logic [1:0] ALUOp, ALUSrcB, PCSource;
  logic [3:0] State;

  logic       na_PCWrite, na_PCWriteCond, na_IorD, na_MemRead, na_MemWrite, na_IRWrite;
  logic       na_MemtoReg, na_RegWrite, na_RegDst, na_ALUSrcA, na_Illegal;
  logic [1:0] na_ALUOp, na_ALUSrcB, na_PCSource;
  logic [3:0] na_State;

  main_control_fsm dut (
    .clock(clock), .reset(reset), .Opcode(Opcode),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .Illegal(Illegal), .State(State)
  );

  main_control_fsm #(.ADDI_EN(1'b0)) dut_na (
    .clock(clock), .reset(reset), .Opcode(Opcode),
    .PCWrite(na_PCWrite), .PCWriteCond(na_PCWriteCond), .IorD(na_IorD), .MemRead(na_MemRead),
    .MemWrite(na_MemWrite), .IRWrite(na_IRWrite), .MemtoReg(na_MemtoReg), .RegWrite(na_RegWrite),
    .RegDst(na_RegDst), .ALUSrcA(na_ALUSrcA), .ALUOp(na_ALUOp), .ALUSrcB(na_ALUSrcB),
    .PCSource(na_PCSource), .Illegal(na_Illegal), .State(na_State)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic pcw, pcwc, iord, mr, mw, irw, m2r, rw, rd, asa;
    logic [1:0] aop, asb, pcs;
    logic ill;
  } outs_t;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic outs_t dut_outs();
    outs_t o;
    o = '{PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
          RegWrite, RegDst, ALUSrcA, ALUOp, ALUSrcB, PCSource, Illegal};
    return o;
  endfunction

  // Expected strobes per state number, straight from the output tables.
  function automatic outs_t exp_outs(int s, logic rst);
    outs_t o;
    o = '0;
    case (s)
      0:     begin o.mr = 1; o.irw = 1; o.asb = 2'b01; o.pcw = 1; end
      1:     o.asb = 2'b11;
      2, 10: begin o.asa = 1; o.asb = 2'b10; end
      3:     begin o.mr = 1; o.iord = 1; end
      4:     begin o.rw = 1; o.m2r = 1; end
      5:     begin o.mw = 1; o.iord = 1; end
      6:     begin o.asa = 1; o.aop = 2'b10; end
      7:     begin o.rw = 1; o.rd = 1; end
      8:     begin o.asa = 1; o.aop = 2'b01; o.pcwc = 1; o.pcs = 2'b01; end
      9:     begin o.pcw = 1; o.pcs = 2'b10; end
      11:    o.rw = 1;
      12:    o.ill = 1;
      default: ;
    endcase
    if (rst) begin o.pcw = 0; o.irw = 0; o.mr = 0; end
    return o;
  endfunction

  typedef int path_t[$];

  // States an instruction visits after DECODE.
  function automatic path_t route(logic [5:0] op);
    path_t p;
    case (op)
      OP_LW:   begin p.push_back(2); p.push_back(3); p.push_back(4); end
      OP_SW:   begin p.push_back(2); p.push_back(5); end
      OP_R:    begin p.push_back(6); p.push_back(7); end
      OP_BEQ:  p.push_back(8);
      OP_J:    p.push_back(9);
      OP_ADDI: begin p.push_back(10); p.push_back(11); end
      default: p.push_back(12);
    endcase
    return p;
  endfunction

  path_t path;
  int    exp_state = 0;
  bit    m_hold = 1'b1;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      path.delete();
      exp_state = 0;
      m_hold = 1'b1;
    end else if (m_hold) begin
      m_hold = 1'b0;
    end else if (exp_state == 0) begin
      exp_state = 1;
    end else if (exp_state == 1) begin
      path = route(Opcode);
      exp_state = path.pop_front();
    end else if (path.size() != 0) begin
      exp_state = path.pop_front();
    end else begin
      exp_state = 0;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("state", 32'(State), 32'(exp_state));
      chk("outputs", 32'(dut_outs()), 32'(exp_outs(exp_state, reset)));
    end
  end

  outs_t seen[6];
  int    na_got[6];
  logic  na_ill[6];

  // Starts and ends on a negedge in FETCH; Opcode is disturbed after DECODE.
  task automatic run_seq(input string nm, input logic [5:0] op, input int req[6], input int len);
    Opcode = op;
    for (int i = 0; i < len; i++) begin
      seen[i]   = dut_outs();
      na_got[i] = int'(na_State);
      na_ill[i] = na_Illegal;
      chk(nm, 32'(State), 32'(req[i]));
      if (i == 2) Opcode = (op == OP_LW) ? OP_SW : OP_LW;
      if (i < len - 1) @(negedge clock);
    end
  endtask

  initial begin
    int n;
    Opcode = OP_R;
    reset  = 1'b1;
    chk_en = 1'b1;
    @(negedge clock);
    chk("rst_state", 32'(State), 32'd0);
    chk("rst_pcwrite", 32'(PCWrite), 32'd0);
    chk("rst_memread", 32'(MemRead), 32'd0);
    chk("rst_irwrite", 32'(IRWrite), 32'd0);
    chk("rst_alusrcb", 32'(ALUSrcB), 32'd1);
    @(negedge clock);
    #2 reset = 1'b0;
    #1 chk("post_rst_pcwrite", 32'(PCWrite), 32'd1);
    @(negedge clock);
    chk("post_rst_hold", 32'(State), 32'd0);

    run_seq("lw_seq", OP_LW, '{0, 1, 2, 3, 4, 0}, 6);
    n = 0;
    for (int i = 0; i < 6; i++) n += int'(seen[i].m2r & seen[i].rw);
    chk("lw_wb_cycles", 32'(n), 32'd1);
    chk("lw_wb_in_s4", 32'({seen[4].m2r, seen[4].rw}), 32'b11);

    run_seq("r_seq", OP_R, '{0, 1, 6, 7, 0, 0}, 5);
    chk("r_aluop", 32'(seen[2].aop), 32'b10);
    chk("r_regdst", 32'(seen[3].rd), 32'd1);

    run_seq("beq_seq", OP_BEQ, '{0, 1, 8, 0, 0, 0}, 4);
    chk("beq_ctrl", 32'({seen[2].aop, seen[2].pcwc, seen[2].pcs}), 32'b01_1_01);

    run_seq("sw_seq", OP_SW, '{0, 1, 2, 5, 0, 0}, 5);
    run_seq("j_seq", OP_J, '{0, 1, 9, 0, 0, 0}, 4);

    run_seq("ill_seq", 6'b111111, '{0, 1, 12, 0, 0, 0}, 4);
    n = 0;
    for (int i = 0; i < 4; i++) n += int'(seen[i].ill);
    chk("ill_pulse", 32'(n), 32'd1);
    chk("ill_writes", 32'({seen[2].pcw, seen[2].pcwc, seen[2].mw, seen[2].irw, seen[2].rw}), 32'd0);

    Opcode = OP_LW;
    for (int i = 0; i < 10 && State != 4'd3; i++) @(negedge clock);
    chk("reach_memrd", 32'(State), 32'd3);
    #2 reset = 1'b1;
    #1 chk("async_rst_state", 32'(State), 32'd0);
    chk("async_rst_memread", 32'(MemRead), 32'd0);
    @(negedge clock);
    #2 reset = 1'b0;
    @(negedge clock);

    run_seq("addi_seq", OP_ADDI, '{0, 1, 10, 11, 0, 0}, 5);
    for (int i = 0; i < 4; i++) begin
      int na_req[4];
      na_req = '{0, 1, 12, 0};
      chk("noaddi_seq", 32'(na_got[i]), 32'(na_req[i]));
    end
    chk("noaddi_illegal", 32'(na_ill[2]), 32'd1);

    @(negedge clock);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
